// File: rtl/blit_pkg.sv
`default_nettype none
//==============================================================================
// Module   : blit_pkg
// Purpose  : Shared constants and the write-entry record for the blitter
//            write queue and its neighbours.
// Contents : BLIT_ADDR_W / BLIT_DATA_W / BLIT_BE_W default widths,
//            blit_wr_t {addr, data, be} write record.
// Revision : 1.0 - initial parametrised release
//==============================================================================
package blit_pkg;

   localparam int BLIT_ADDR_W = 26;
   localparam int BLIT_DATA_W = 32;
   localparam int BLIT_BE_W   = BLIT_DATA_W / 8;

   typedef struct packed {
      logic [BLIT_ADDR_W-1:0] addr;
      logic [BLIT_DATA_W-1:0] data;
      logic [BLIT_BE_W-1:0]   be;
   } blit_wr_t;

endpackage
`default_nettype wire

// File: rtl/blit_write_queue_if.sv
`default_nettype none
//==============================================================================
// Module   : blit_write_queue_if
// Purpose  : Bus bundle between the blitter write stage, the write queue and
//            the SDRAM arbiter write port.
// Signals  : in_write/in_addr/in_data/in_byte_enable  blitter -> queue
//            in_full                                  queue -> blitter
//            out_req/out_addr/out_data/out_byte_enable queue -> arbiter
//            out_ack                                  arbiter -> queue
// Modports : slave  - the queue
//            master - the surrounding environment (blitter + arbiter)
// Revision : 1.0 - initial parametrised release
//==============================================================================
interface blit_write_queue_if
   import blit_pkg::*;
#(
   parameter int ADDR_W = BLIT_ADDR_W,
   parameter int DATA_W = BLIT_DATA_W
);
   localparam int BE_W = DATA_W / 8;

   logic              in_write;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic [BE_W-1:0]   in_byte_enable;
   logic              in_full;

   logic              out_req;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic [BE_W-1:0]   out_byte_enable;
   logic              out_ack;

   modport slave (
      input  in_write, in_addr, in_data, in_byte_enable, out_ack,
      output in_full, out_req, out_addr, out_data, out_byte_enable
   );

   modport master (
      output in_write, in_addr, in_data, in_byte_enable, out_ack,
      input  in_full, out_req, out_addr, out_data, out_byte_enable
   );

endinterface
`default_nettype wire

// File: rtl/blit_wq_ram.sv
`default_nettype none
//==============================================================================
// Module   : blit_wq_ram
// Purpose  : Simple dual-port storage for the write queue: one write port,
//            one read port with a registered output (block-RAM friendly).
// Ports    : clock     clock
//            i_we      write enable
//            i_waddr   write address
//            i_wdata   write data
//            i_raddr   read address, captured every cycle
//            o_rdata   data at i_raddr from the previous cycle
// Revision : 1.0 - initial release
//==============================================================================
module blit_wq_ram #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 62
)(
   input  logic                     clock,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Read-before-write on an address collision; the queue never relies on
   // reading a slot in the same cycle it is written.
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/blit_write_queue.sv
`default_nettype none
//==============================================================================
// Module   : blit_write_queue
// Purpose  : Buffers blitter pixel/word writes and issues them to the memory
//            arbiter. Stage register (with write-combining of consecutive
//            writes to one word) -> storage RAM -> output register.
// Ports    : clock, reset   clock and synchronous active-high reset
//            bus (slave)    write input, almost-full, req/ack output
//            level          entries held (stage + storage + output register)
//            idle           queue completely empty
//            overflow       sticky, set when an incoming write was dropped
// Revision : 1.0 - initial parametrised release
//==============================================================================
module blit_write_queue
   import blit_pkg::*;
#(
   parameter int ADDR_W      = BLIT_ADDR_W,
   parameter int DATA_W      = BLIT_DATA_W,
   parameter int DEPTH       = 256,
   parameter int FULL_MARGIN = 8,
   parameter int COMBINE     = 1
)(
   input  logic                     clock,
   input  logic                     reset,
   blit_write_queue_if.slave        bus,
   output logic [$clog2(DEPTH)+1:0] level,
   output logic                     idle,
   output logic                     overflow
);

   localparam int BE_W  = DATA_W / 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;
   localparam int LVL_W = AW + 2;
   localparam int ENT_W = ADDR_W + DATA_W + BE_W;

   // Stage register
   logic              r_stage_valid;
   logic [ADDR_W-1:0] r_stage_addr;
   logic [DATA_W-1:0] r_stage_data;
   logic [BE_W-1:0]   r_stage_be;

   // Storage pointers carry a wrap bit above the slot index
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   // RAM output currently holds the entry at r_rd_ptr
   logic              r_head_ok;

   // Output register and status
   logic              r_out_req;
   logic [ADDR_W-1:0] r_out_addr;
   logic [DATA_W-1:0] r_out_data;
   logic [BE_W-1:0]   r_out_be;
   logic              r_in_full;
   logic [LVL_W-1:0]  r_level;
   logic              r_overflow;

   logic              w_empty;
   logic              w_full;
   logic [PTR_W-1:0]  w_count;
   logic [PTR_W-1:0]  w_free;
   logic              w_merge;
   logic              w_push;
   logic              w_drop;
   logic              w_load_out;
   logic              w_pop;
   logic [PTR_W-1:0]  w_wr_nxt;
   logic [PTR_W-1:0]  w_rd_nxt;
   logic [PTR_W-1:0]  w_count_nxt;
   logic              w_stage_valid_nxt;
   logic              w_out_req_nxt;
   logic [LVL_W-1:0]  w_level_nxt;
   logic [DATA_W-1:0] w_merge_data;
   logic [ENT_W-1:0]  w_ram_wdata;
   logic [ENT_W-1:0]  w_ram_q;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_free  = PTR_W'(DEPTH) - w_count;

   assign w_merge = bus.in_write && r_stage_valid && (COMBINE != 0) &&
                    (bus.in_addr == r_stage_addr);
   // Any valid stage that is not absorbing a merge leaves for storage.
   assign w_push  = r_stage_valid && !w_merge && !w_full;
   assign w_drop  = bus.in_write && r_stage_valid && !w_merge && w_full;

   assign w_load_out = !r_out_req || bus.out_ack;
   assign w_pop      = w_load_out && r_head_ok;

   assign w_wr_nxt    = r_wr_ptr + PTR_W'(w_push);
   assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);
   assign w_count_nxt = w_wr_nxt - w_rd_nxt;

   // A write always leaves the stage occupied (loaded, merged or retained).
   assign w_stage_valid_nxt = bus.in_write || (r_stage_valid && !w_push);
   assign w_out_req_nxt     = w_load_out ? w_pop : r_out_req;
   assign w_level_nxt       = LVL_W'(w_stage_valid_nxt) + LVL_W'(w_count_nxt) +
                              LVL_W'(w_out_req_nxt);

   always_comb begin
      w_merge_data = r_stage_data;
      for (int i = 0; i < BE_W; i++) begin
         if (bus.in_byte_enable[i]) begin
            w_merge_data[8*i +: 8] = bus.in_data[8*i +: 8];
         end
      end
   end

   assign w_ram_wdata = {r_stage_addr, r_stage_data, r_stage_be};

   // Read address runs one entry ahead on a pop so the next head is ready
   // in the RAM output register on the cycle after an ack.
   blit_wq_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_ram (
      .clock   (clock),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (w_ram_wdata),
      .i_raddr (w_rd_nxt[AW-1:0]),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_stage_valid <= 1'b0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_head_ok     <= 1'b0;
         r_out_req     <= 1'b0;
         r_in_full     <= 1'b0;
         r_level       <= '0;
         r_overflow    <= 1'b0;
      end else begin
         if (w_merge) begin
            r_stage_data <= w_merge_data;
            r_stage_be   <= r_stage_be | bus.in_byte_enable;
         end else if (bus.in_write) begin
            if (!w_drop) begin
               r_stage_valid <= 1'b1;
               r_stage_addr  <= bus.in_addr;
               r_stage_data  <= bus.in_data;
               r_stage_be    <= bus.in_byte_enable;
            end
         end else if (w_push) begin
            r_stage_valid <= 1'b0;
         end

         if (w_drop) begin
            r_overflow <= 1'b1;
         end

         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         // The slot just addressed was written before this edge only if it
         // differs from the pre-push write pointer; otherwise the RAM output
         // is stale (empty slot or same-cycle write) and must be re-read.
         r_head_ok <= (w_rd_nxt != r_wr_ptr);

         if (w_load_out) begin
            r_out_req <= w_pop;
            if (w_pop) begin
               r_out_addr <= w_ram_q[ENT_W-1 -: ADDR_W];
               r_out_data <= w_ram_q[BE_W +: DATA_W];
               r_out_be   <= w_ram_q[BE_W-1:0];
            end
         end

         r_in_full <= (w_free < PTR_W'(FULL_MARGIN));
         r_level   <= w_level_nxt;
      end
   end

   assign bus.in_full         = r_in_full;
   assign bus.out_req         = r_out_req;
   assign bus.out_addr        = r_out_addr;
   assign bus.out_data        = r_out_data;
   assign bus.out_byte_enable = r_out_be;

   assign level    = r_level;
   assign idle     = !r_stage_valid && w_empty && !r_out_req;
   assign overflow = r_overflow;

endmodule
`default_nettype wire
